// File: rtl/bp_zynq_fill_pkg.sv
// Shared types and defaults for the ZynqParrot fill-port arbiter.
// The header layout is {wr, len (beats-1), paddr}, MSB first.
package bp_zynq_fill_pkg;

  localparam int unsigned bp_num_req_gp       = 2;
  localparam int unsigned bp_paddr_width_gp   = 34;
  localparam int unsigned bp_fill_width_gp    = 64;
  localparam int unsigned bp_max_beats_gp     = 8;
  localparam int unsigned bp_max_outstanding_gp = 4;
  localparam int unsigned bp_lg_beats_gp      = $clog2(bp_max_beats_gp);

  typedef struct packed {
    logic                         wr;
    logic [bp_lg_beats_gp-1:0]    len;
    logic [bp_paddr_width_gp-1:0] paddr;
  } bp_zynq_fill_hdr_s;

  localparam logic [0:0] e_idle = 1'b0;
  localparam logic [0:0] e_data = 1'b1;

  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/bp_zynq_fill_arbiter_chk.sv
// Simulation checks on the response stream: the owner id must be a real requester
// and a closing beat must never retire a request that was never issued.
module bp_zynq_fill_arbiter_chk
#(parameter int unsigned num_req_p     = 2
 ,parameter int unsigned lg_num_req_lp = 1
 )
 (input logic                     clk_i
 ,input logic                     reset_i
 ,input logic                     mem_resp_v_i
 ,input logic [lg_num_req_lp-1:0] mem_resp_id_i
 ,input logic                     resp_fire_last_i
 ,input logic                     resp_cnt_zero_i
 );

  resp_id_in_range: assert property (@(posedge clk_i) disable iff (reset_i)
    mem_resp_v_i |-> (32'(mem_resp_id_i) < num_req_p))
    else $error("response id %0d has no requester", mem_resp_id_i);

  resp_no_underflow: assert property (@(posedge clk_i) disable iff (reset_i)
    resp_fire_last_i |-> !resp_cnt_zero_i)
    else $error("response retires id %0d with no outstanding request", mem_resp_id_i);

endmodule

// File: rtl/bp_zynq_fill_rr_arb.sv
// Round-robin picker starting at ptr_i; once a grant stalls downstream (hold_i)
// the same index is kept until it is accepted, so the header cannot change under a pending valid.
module bp_zynq_fill_rr_arb
  import bp_zynq_fill_pkg::*;
#(parameter int unsigned num_req_p     = bp_num_req_gp
 ,localparam int unsigned lg_num_req_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1
 )
 (input  logic                     clk_i
 ,input  logic                     reset_i
 ,input  logic [num_req_p-1:0]     req_i
 ,input  logic [lg_num_req_lp-1:0] ptr_i
 ,input  logic                     hold_i
 ,output logic [num_req_p-1:0]     grant_o
 ,output logic [lg_num_req_lp-1:0] idx_o
 ,output logic                     v_o
 );

  logic                     lock_q, lock_d;
  logic [lg_num_req_lp-1:0] lock_idx_q, lock_idx_d;
  logic [lg_num_req_lp-1:0] rr_idx_s;
  logic                     use_lock_s;

  // Scan from the farthest offset down so the nearest eligible index wins.
  always_comb begin
    rr_idx_s = ptr_i;
    for (int k = num_req_p - 1; k >= 0; k--) begin
      rr_idx_s = req_i[(int'(ptr_i) + k) % num_req_p]
               ? lg_num_req_lp'((int'(ptr_i) + k) % num_req_p) : rr_idx_s;
    end
  end

  // Final grant selection with lock override.
  always_comb begin
    use_lock_s = lock_q & req_i[lock_idx_q];
    idx_o      = use_lock_s ? lock_idx_q : rr_idx_s;
    v_o        = |req_i;
    grant_o    = v_o ? (num_req_p'(1) << idx_o) : {num_req_p{1'b0}};
    lock_d     = hold_i;
    lock_idx_d = hold_i ? idx_o : lock_idx_q;
  end

  // Lock state registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      lock_q     <= 1'b0;
      lock_idx_q <= {lg_num_req_lp{1'b0}};
    end else begin
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
    end
  end

endmodule

// File: rtl/bp_zynq_fill_arbiter.sv
// Shares one 64-bit fill port between cache requesters: round-robin header grant,
// write-data bursts locked to the writer, and responses routed back by id.
module bp_zynq_fill_arbiter
  import bp_zynq_fill_pkg::*;
#(parameter int unsigned num_req_p         = bp_num_req_gp
 ,parameter int unsigned paddr_width_p     = bp_paddr_width_gp
 ,parameter int unsigned fill_width_p      = bp_fill_width_gp
 ,parameter int unsigned max_beats_p       = bp_max_beats_gp
 ,parameter int unsigned max_outstanding_p = bp_max_outstanding_gp
 ,localparam int unsigned lg_num_req_lp    = (num_req_p > 1) ? $clog2(num_req_p) : 1
 ,localparam int unsigned lg_beats_lp      = $clog2(max_beats_p)
 ,localparam int unsigned hdr_width_lp     = 1 + lg_beats_lp + paddr_width_p
 ,localparam int unsigned cnt_width_lp     = $clog2(max_outstanding_p + 1)
 )
 (input  logic                              clk_i
 ,input  logic                              reset_i
 ,input  logic [num_req_p-1:0]              req_v_i
 ,output logic [num_req_p-1:0]              req_ready_and_o
 ,input  logic [num_req_p*hdr_width_lp-1:0] req_hdr_i
 ,input  logic [num_req_p-1:0]              req_data_v_i
 ,output logic [num_req_p-1:0]              req_data_ready_and_o
 ,input  logic [num_req_p*fill_width_p-1:0] req_data_i
 ,output logic                              mem_v_o
 ,input  logic                              mem_ready_and_i
 ,output logic [hdr_width_lp-1:0]           mem_hdr_o
 ,output logic [lg_num_req_lp-1:0]          mem_id_o
 ,output logic                              mem_data_v_o
 ,input  logic                              mem_data_ready_and_i
 ,output logic [fill_width_p-1:0]           mem_data_o
 ,input  logic                              mem_resp_v_i
 ,output logic                              mem_resp_ready_and_o
 ,input  logic [lg_num_req_lp-1:0]          mem_resp_id_i
 ,input  logic                              mem_resp_last_i
 ,input  logic [fill_width_p-1:0]           mem_resp_data_i
 ,output logic [num_req_p-1:0]              resp_v_o
 ,input  logic [num_req_p-1:0]              resp_ready_and_i
 ,output logic                              resp_last_o
 ,output logic [fill_width_p-1:0]           resp_data_o
 );

  logic [0:0]               state_q, state_d;
  logic [lg_num_req_lp-1:0] ptr_q, ptr_d, id_q, id_d;
  logic [lg_beats_lp-1:0]   beats_q, beats_d;
  logic [cnt_width_lp-1:0]  cnt_q [num_req_p];
  logic [cnt_width_lp-1:0]  cnt_d [num_req_p];

  logic [num_req_p-1:0]     eligible_s, grant_s;
  logic [lg_num_req_lp-1:0] win_s;
  logic                     arb_v_s, hdr_fire_s, beat_fire_s, in_data_s;
  logic                     resp_id_ok_s, resp_fire_last_s, resp_cnt_zero_s;
  logic [hdr_width_lp-1:0]  win_hdr_s;

  // A requester at its outstanding limit drops out of arbitration.
  always_comb begin
    for (int i = 0; i < num_req_p; i++) begin
      eligible_s[i] = req_v_i[i] & (cnt_q[i] < cnt_width_lp'(max_outstanding_p));
    end
  end

  bp_zynq_fill_rr_arb #(.num_req_p(num_req_p)) rr_arb
    (.clk_i   (clk_i)
    ,.reset_i (reset_i)
    ,.req_i   (eligible_s)
    ,.ptr_i   (ptr_q)
    ,.hold_i  (mem_v_o & ~mem_ready_and_i)
    ,.grant_o (grant_s)
    ,.idx_o   (win_s)
    ,.v_o     (arb_v_s)
    );

  // Header, write-beat and response steering; outputs are forced low while reset is held.
  always_comb begin
    win_hdr_s            = req_hdr_i[int'(win_s)*hdr_width_lp +: hdr_width_lp];
    mem_v_o              = ~reset_i & (state_q == e_idle) & arb_v_s;
    mem_hdr_o            = win_hdr_s;
    mem_id_o             = win_s;
    hdr_fire_s           = mem_v_o & mem_ready_and_i;
    req_ready_and_o      = hdr_fire_s ? grant_s : {num_req_p{1'b0}};

    in_data_s            = ~reset_i & (state_q == e_data);
    mem_data_v_o         = in_data_s & req_data_v_i[id_q];
    mem_data_o           = req_data_i[int'(id_q)*fill_width_p +: fill_width_p];
    req_data_ready_and_o = in_data_s ? (num_req_p'(mem_data_ready_and_i) << id_q)
                                     : {num_req_p{1'b0}};
    beat_fire_s          = mem_data_v_o & mem_data_ready_and_i;

    resp_id_ok_s         = 32'(mem_resp_id_i) < num_req_p;
    resp_v_o             = (~reset_i & mem_resp_v_i & resp_id_ok_s)
                         ? (num_req_p'(1) << mem_resp_id_i) : {num_req_p{1'b0}};
    mem_resp_ready_and_o = ~reset_i & resp_id_ok_s & resp_ready_and_i[mem_resp_id_i];
    resp_fire_last_s     = mem_resp_v_i & mem_resp_ready_and_o & mem_resp_last_i;
    resp_cnt_zero_s      = resp_id_ok_s ? (cnt_q[mem_resp_id_i] == {cnt_width_lp{1'b0}}) : 1'b0;
    resp_last_o          = mem_resp_last_i;
    resp_data_o          = mem_resp_data_i;
  end

  // Burst FSM: a write header locks the data channel to its owner for len+1 beats.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    beats_d = beats_q;
    case (state_q)
      e_idle: begin
        if (hdr_fire_s) begin
          ptr_d = lg_num_req_lp'(wrap_inc(32'(win_s), num_req_p));
          if (win_hdr_s[hdr_width_lp-1]) begin
            state_d = e_data;
            id_d    = win_s;
            beats_d = win_hdr_s[hdr_width_lp-2 -: lg_beats_lp];
          end else begin
            state_d = e_idle;
          end
        end else begin
          state_d = e_idle;
        end
      end
      e_data: begin
        if (beat_fire_s && (beats_q == {lg_beats_lp{1'b0}})) begin
          state_d = e_idle;
        end else if (beat_fire_s) begin
          beats_d = beats_q - lg_beats_lp'(1);
        end else begin
          state_d = e_data;
        end
      end
      default: state_d = e_idle;
    endcase
  end

  // Outstanding counts: +1 on header grant, -1 on the closing response beat.
  always_comb begin
    for (int i = 0; i < num_req_p; i++) begin
      cnt_d[i] = cnt_q[i]
               + cnt_width_lp'(hdr_fire_s & grant_s[i])
               - cnt_width_lp'(resp_fire_last_s & resp_id_ok_s
                               & (mem_resp_id_i == lg_num_req_lp'(i))
                               & (cnt_q[i] != {cnt_width_lp{1'b0}}));
    end
  end

  // State registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= e_idle;
      ptr_q   <= {lg_num_req_lp{1'b0}};
      id_q    <= {lg_num_req_lp{1'b0}};
      beats_q <= {lg_beats_lp{1'b0}};
      for (int i = 0; i < num_req_p; i++) cnt_q[i] <= {cnt_width_lp{1'b0}};
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      beats_q <= beats_d;
      for (int i = 0; i < num_req_p; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  bp_zynq_fill_arbiter_chk #(.num_req_p(num_req_p), .lg_num_req_lp(lg_num_req_lp)) chk
    (.clk_i            (clk_i)
    ,.reset_i          (reset_i)
    ,.mem_resp_v_i     (mem_resp_v_i)
    ,.mem_resp_id_i    (mem_resp_id_i)
    ,.resp_fire_last_i (resp_fire_last_s)
    ,.resp_cnt_zero_i  (resp_cnt_zero_s)
    );

endmodule

// File: tb/tb_bp_zynq_fill_arbiter.sv
// Bench for bp_zynq_fill_arbiter: directed scenarios plus a randomized phase, all
// checked against a queue-free model of outstanding counts, rr pointer and grant lock.
module tb_bp_zynq_fill_arbiter;

  localparam int HW = 38;
  localparam int FW = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      req_v, req_ready, req_data_v, req_data_ready, resp_v, resp_ready;
  logic [2*HW-1:0] req_hdr;
  logic [2*FW-1:0] req_data;
  logic            mem_v, mem_ready, mem_data_v, mem_data_ready;
  logic [HW-1:0]   mem_hdr;
  logic [0:0]      mem_id, mem_resp_id;
  logic [FW-1:0]   mem_data, mem_resp_data, resp_data;
  logic            mem_resp_v, mem_resp_ready, mem_resp_last, resp_last;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_cnt [2];
  int exp_ptr;

  always #5 clk = ~clk;

  bp_zynq_fill_arbiter dut
    (.clk_i(clk), .reset_i(rst)
    ,.req_v_i(req_v), .req_ready_and_o(req_ready), .req_hdr_i(req_hdr)
    ,.req_data_v_i(req_data_v), .req_data_ready_and_o(req_data_ready), .req_data_i(req_data)
    ,.mem_v_o(mem_v), .mem_ready_and_i(mem_ready), .mem_hdr_o(mem_hdr), .mem_id_o(mem_id)
    ,.mem_data_v_o(mem_data_v), .mem_data_ready_and_i(mem_data_ready), .mem_data_o(mem_data)
    ,.mem_resp_v_i(mem_resp_v), .mem_resp_ready_and_o(mem_resp_ready), .mem_resp_id_i(mem_resp_id)
    ,.mem_resp_last_i(mem_resp_last), .mem_resp_data_i(mem_resp_data)
    ,.resp_v_o(resp_v), .resp_ready_and_i(resp_ready), .resp_last_o(resp_last), .resp_data_o(resp_data)
    );

  // Model: next round-robin winner among requesters with room for another request.
  function automatic int rr_pick(input logic [1:0] v);
    for (int k = 0; k < 2; k++) begin
      int i;
      i = (exp_ptr + k) % 2;
      if (v[i] && exp_cnt[i] < 4) return i;
    end
    return -1;
  endfunction

  function automatic logic [HW-1:0] mk_hdr(input logic wr, input logic [2:0] len);
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return {wr, len, r[33:0]};
  endfunction

  function automatic void grant_model(input int w);
    exp_cnt[w]++;
    exp_ptr = (w + 1) % 2;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    req_v = 2'b00; req_hdr = '0; req_data_v = 2'b00; req_data = '0;
    mem_ready = 1'b0; mem_data_ready = 1'b0;
    mem_resp_v = 1'b0; mem_resp_id = 1'b0; mem_resp_last = 1'b0; mem_resp_data = '0;
    resp_ready = 2'b00;
  endtask

  task automatic test_reset;
    #12;
    req_v = 2'b11; req_data_v = 2'b11; mem_ready = 1'b1; mem_data_ready = 1'b1;
    mem_resp_v = 1'b1; resp_ready = 2'b11;
    #1;
    n_checks += 6;
    if (mem_v !== 1'b0) begin n_fail++; $display("FAIL reset_mem_v: got %b want 0", mem_v); end
    if (req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_req_ready: got %b want 00", req_ready); end
    if (mem_data_v !== 1'b0) begin n_fail++; $display("FAIL reset_mem_data_v: got %b want 0", mem_data_v); end
    if (req_data_ready !== 2'b00) begin n_fail++; $display("FAIL reset_data_ready: got %b want 00", req_data_ready); end
    if (resp_v !== 2'b00) begin n_fail++; $display("FAIL reset_resp_v: got %b want 00", resp_v); end
    if (mem_resp_ready !== 1'b0) begin n_fail++; $display("FAIL reset_resp_ready: got %b want 0", mem_resp_ready); end
    clear_inputs();
    @(negedge clk);
    rst = 1'b0;
    exp_cnt[0] = 0; exp_cnt[1] = 0; exp_ptr = 0;
    tick();
  endtask

  // Retire every outstanding request with single-beat last responses.
  task automatic test_resp_single;
    for (int id = 0; id < 2; id++) begin
      while (exp_cnt[id] > 0) begin
        logic [1:0] oh;
        mem_resp_v = 1'b1; mem_resp_id = 1'(id); mem_resp_last = 1'b1;
        mem_resp_data = {$urandom(), $urandom()}; resp_ready = 2'b11;
        oh = 2'b01 << id;
        @(negedge clk);
        n_checks += 3;
        if (resp_v !== oh) begin n_fail++; $display("FAIL single_resp_v: got %b want %b", resp_v, oh); end
        if (mem_resp_ready !== 1'b1) begin n_fail++; $display("FAIL single_resp_ready: got %b want 1", mem_resp_ready); end
        if (resp_data !== mem_resp_data || resp_last !== 1'b1) begin
          n_fail++; $display("FAIL single_resp_data: got %h/%b want %h/1", resp_data, resp_last, mem_resp_data);
        end
        exp_cnt[id]--;
        tick();
      end
    end
    clear_inputs();
  endtask

  task automatic test_rr_reads;
    req_v = 2'b11; mem_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      int w;
      req_hdr[HW-1:0] = mk_hdr(1'b0, 3'($urandom));
      req_hdr[2*HW-1:HW] = mk_hdr(1'b0, 3'($urandom));
      w = rr_pick(req_v);
      @(negedge clk);
      n_checks += 2;
      if (mem_v !== 1'b1 || mem_id !== 1'(w)) begin
        n_fail++; $display("FAIL rr_grant: got v=%b id=%0d want v=1 id=%0d", mem_v, mem_id, w);
      end
      if (req_ready !== (2'b01 << w) || mem_hdr !== req_hdr[w*HW +: HW]) begin
        n_fail++; $display("FAIL rr_ready_hdr: got %b/%h want %b/%h", req_ready, mem_hdr, 2'b01 << w, req_hdr[w*HW +: HW]);
      end
      grant_model(w);
      tick();
    end
    clear_inputs();
    test_resp_single();
  endtask

  task automatic test_write_burst;
    int left;
    int budget;
    req_v = 2'b01; mem_ready = 1'b1;
    req_hdr[HW-1:0] = mk_hdr(1'b1, 3'd3);
    req_hdr[2*HW-1:HW] = mk_hdr(1'b0, 3'd0);
    @(negedge clk);
    n_checks++;
    if (mem_v !== 1'b1 || mem_id !== 1'b0 || req_ready !== 2'b01) begin
      n_fail++; $display("FAIL wr_hdr: got v=%b id=%0d rdy=%b want 1/0/01", mem_v, mem_id, req_ready);
    end
    grant_model(0);
    tick();
    req_v = 2'b10;
    left = 4; budget = 40;
    while (left > 0 && budget > 0) begin
      logic dv;
      dv = 1'($urandom);
      req_data = {$urandom(), $urandom(), $urandom(), $urandom()};
      req_data_v = {1'b1, dv};
      mem_data_ready = 1'($urandom);
      @(negedge clk);
      n_checks += 2;
      if (mem_v !== 1'b0 || req_ready !== 2'b00) begin
        n_fail++; $display("FAIL wr_hdr_blocked: got v=%b rdy=%b want 0/00", mem_v, req_ready);
      end
      if (mem_data_v !== dv || req_data_ready !== {1'b0, mem_data_ready} || (dv && mem_data !== req_data[FW-1:0])) begin
        n_fail++; $display("FAIL wr_beat: got v=%b rdy=%b d=%h want %b/%b/%h",
                           mem_data_v, req_data_ready, mem_data, dv, {1'b0, mem_data_ready}, req_data[FW-1:0]);
      end
      if (dv && mem_data_ready) left--;
      budget--;
      tick();
    end
    n_checks++;
    if (left != 0) begin n_fail++; $display("FAIL wr_beat_budget: got %0d beats left want 0", left); end
    req_data_v = 2'b00; mem_data_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (mem_v !== 1'b1 || mem_id !== 1'b1 || req_ready !== 2'b10) begin
      n_fail++; $display("FAIL wr_next_hdr: got v=%b id=%0d rdy=%b want 1/1/10", mem_v, mem_id, req_ready);
    end
    grant_model(1);
    tick();
    clear_inputs();
    test_resp_single();
  endtask

  task automatic test_stall;
    int w;
    int q;
    q = (exp_ptr + 1) % 2;
    req_hdr[HW-1:0] = mk_hdr(1'b0, 3'd1);
    req_hdr[2*HW-1:HW] = mk_hdr(1'b0, 3'd2);
    req_v = 2'b01 << q; mem_ready = 1'b0;
    w = rr_pick(req_v);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_checks += 2;
      if (mem_v !== 1'b1 || mem_id !== 1'(w) || mem_hdr !== req_hdr[w*HW +: HW]) begin
        n_fail++; $display("FAIL stall_hold: got v=%b id=%0d want v=1 id=%0d", mem_v, mem_id, w);
      end
      if (req_ready !== 2'b00) begin n_fail++; $display("FAIL stall_ready: got %b want 00", req_ready); end
      tick();
      req_v = 2'b11;
    end
    mem_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (mem_id !== 1'(w) || req_ready !== (2'b01 << w)) begin
      n_fail++; $display("FAIL stall_release: got id=%0d rdy=%b want id=%0d", mem_id, req_ready, w);
    end
    grant_model(w);
    tick();
    clear_inputs();
    test_resp_single();
  endtask

  task automatic test_max_outstanding;
    req_v = 2'b10; mem_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      req_hdr[2*HW-1:HW] = mk_hdr(1'b0, 3'($urandom));
      @(negedge clk);
      n_checks++;
      if (mem_v !== 1'b1 || mem_id !== 1'b1 || req_ready !== 2'b10) begin
        n_fail++; $display("FAIL maxout_accept%0d: got v=%b id=%0d rdy=%b want 1/1/10", c, mem_v, mem_id, req_ready);
      end
      grant_model(1);
      tick();
    end
    mem_resp_v = 1'b1; mem_resp_id = 1'b1; mem_resp_last = 1'b1; resp_ready = 2'b10;
    @(negedge clk);
    n_checks += 2;
    if (mem_v !== (rr_pick(req_v) >= 0) || req_ready !== 2'b00) begin
      n_fail++; $display("FAIL maxout_block: got v=%b rdy=%b want 0/00", mem_v, req_ready);
    end
    if (resp_v !== 2'b10 || mem_resp_ready !== 1'b1) begin
      n_fail++; $display("FAIL maxout_resp: got %b/%b want 10/1", resp_v, mem_resp_ready);
    end
    exp_cnt[1]--;
    tick();
    mem_resp_v = 1'b0; mem_resp_last = 1'b0;
    @(negedge clk);
    n_checks++;
    if (mem_v !== 1'b1 || req_ready !== 2'b10) begin
      n_fail++; $display("FAIL maxout_unblock: got v=%b rdy=%b want 1/10", mem_v, req_ready);
    end
    grant_model(1);
    tick();
    clear_inputs();
    test_resp_single();
  endtask

  task automatic test_resp_burst;
    int beat;
    int budget;
    logic tog;
    req_v = 2'b01; mem_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      req_hdr[HW-1:0] = mk_hdr(1'b0, 3'd7);
      @(negedge clk);
      n_checks++;
      if (req_ready !== 2'b01) begin n_fail++; $display("FAIL burst_fill%0d: got %b want 01", c, req_ready); end
      grant_model(0);
      tick();
    end
    beat = 0; budget = 40; tog = 1'b0;
    while (beat < 8 && budget > 0) begin
      logic last;
      last = (beat == 7);
      mem_resp_v = 1'b1; mem_resp_id = 1'b0; mem_resp_last = last;
      mem_resp_data = {$urandom(), $urandom()};
      resp_ready = {1'($urandom), tog};
      @(negedge clk);
      n_checks += 3;
      if (mem_resp_ready !== tog || resp_v !== 2'b01) begin
        n_fail++; $display("FAIL burst_ready: got rdy=%b v=%b want %b/01", mem_resp_ready, resp_v, tog);
      end
      if (resp_data !== mem_resp_data || resp_last !== last) begin
        n_fail++; $display("FAIL burst_data: got %h/%b want %h/%b", resp_data, resp_last, mem_resp_data, last);
      end
      if (mem_v !== (rr_pick(req_v) >= 0)) begin
        n_fail++; $display("FAIL burst_cnt_hold: beat %0d got v=%b want %b", beat, mem_v, rr_pick(req_v) >= 0);
      end
      if (tog) begin
        if (last) exp_cnt[0]--;
        beat++;
      end
      budget--;
      tog = ~tog;
      tick();
    end
    mem_resp_v = 1'b0; mem_resp_last = 1'b0;
    @(negedge clk);
    n_checks++;
    if (mem_v !== 1'b1 || req_ready !== 2'b01) begin
      n_fail++; $display("FAIL burst_release: got v=%b rdy=%b want 1/01", mem_v, req_ready);
    end
    grant_model(0);
    tick();
    clear_inputs();
    test_resp_single();
  endtask

  task automatic test_random;
    int lock_id;
    lock_id = -1;
    for (int c = 0; c < 200; c++) begin
      int w;
      int rid;
      logic [1:0] v;
      logic [1:0] exp_rv;
      v = 2'($urandom);
      for (int i = 0; i < 2; i++) begin
        if (i == lock_id) v[i] = 1'b1;
        else req_hdr[i*HW +: HW] = mk_hdr(1'b0, 3'($urandom));
      end
      req_v = v;
      mem_ready = 1'($urandom);
      rid = $urandom_range(1, 0);
      mem_resp_v = (exp_cnt[rid] > 0) && 1'($urandom);
      mem_resp_id = 1'(rid);
      mem_resp_last = 1'($urandom);
      resp_ready = 2'($urandom);
      w = (lock_id >= 0) ? lock_id : rr_pick(v);
      exp_rv = mem_resp_v ? (2'b01 << rid) : 2'b00;
      @(negedge clk);
      n_checks += 3;
      if (mem_v !== (w >= 0) || (w >= 0 && (mem_id !== 1'(w) || mem_hdr !== req_hdr[w*HW +: HW]))) begin
        n_fail++; $display("FAIL rand_grant: cyc %0d got v=%b id=%0d want winner %0d", c, mem_v, mem_id, w);
      end
      if (req_ready !== ((w >= 0 && mem_ready) ? (2'b01 << w) : 2'b00)) begin
        n_fail++; $display("FAIL rand_ready: cyc %0d got %b winner %0d rdy %b", c, req_ready, w, mem_ready);
      end
      if (resp_v !== exp_rv || mem_resp_ready !== resp_ready[rid]) begin
        n_fail++; $display("FAIL rand_resp: cyc %0d got %b/%b want %b/%b", c, resp_v, mem_resp_ready, exp_rv, resp_ready[rid]);
      end
      if (w >= 0 && mem_ready) begin
        grant_model(w);
        lock_id = -1;
      end else begin
        lock_id = w;
      end
      if (mem_resp_v && resp_ready[rid] && mem_resp_last) exp_cnt[rid]--;
      tick();
    end
    clear_inputs();
    test_resp_single();
  endtask

  task automatic test_reset_mid_burst;
    req_v = 2'b01; mem_ready = 1'b1;
    req_hdr[HW-1:0] = mk_hdr(1'b1, 3'd3);
    @(negedge clk);
    n_checks++;
    if (req_ready !== 2'b01) begin n_fail++; $display("FAIL rst_burst_hdr: got %b want 01", req_ready); end
    grant_model(0);
    tick();
    req_v = 2'b00; req_data_v = 2'b01; mem_data_ready = 1'b1;
    tick();
    tick();
    req_v = 2'b11; req_data_v = 2'b11; mem_ready = 1'b1; mem_resp_v = 1'b1; resp_ready = 2'b11;
    #1;
    n_checks++;
    if (mem_data_v !== 1'b1) begin n_fail++; $display("FAIL rst_burst_beat3: got %b want 1", mem_data_v); end
    #1 rst = 1'b1;
    #1;
    n_checks += 3;
    if (mem_v !== 1'b0 || req_ready !== 2'b00) begin
      n_fail++; $display("FAIL rst_mid_hdr: got v=%b rdy=%b want 0/00", mem_v, req_ready);
    end
    if (mem_data_v !== 1'b0 || req_data_ready !== 2'b00) begin
      n_fail++; $display("FAIL rst_mid_data: got v=%b rdy=%b want 0/00", mem_data_v, req_data_ready);
    end
    if (resp_v !== 2'b00 || mem_resp_ready !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_resp: got v=%b rdy=%b want 00/0", resp_v, mem_resp_ready);
    end
    exp_cnt[0] = 0; exp_cnt[1] = 0; exp_ptr = 0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks += 2;
    if (mem_v !== 1'b1 || mem_id !== 1'b0 || req_ready !== 2'b01) begin
      n_fail++; $display("FAIL rst_after_idle: got v=%b id=%0d rdy=%b want 1/0/01", mem_v, mem_id, req_ready);
    end
    if (mem_data_v !== 1'b0 || req_data_ready !== 2'b00) begin
      n_fail++; $display("FAIL rst_after_data: got v=%b rdy=%b want 0/00", mem_data_v, req_data_ready);
    end
    clear_inputs();
    tick();
    req_v = 2'b01; mem_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      int w;
      req_hdr[HW-1:0] = mk_hdr(1'b0, 3'd0);
      w = rr_pick(req_v);
      @(negedge clk);
      n_checks++;
      if (mem_v !== (w >= 0)) begin
        n_fail++; $display("FAIL rst_cnt_cleared%0d: got v=%b want %b", c, mem_v, w >= 0);
      end
      if (w >= 0) grant_model(w);
      tick();
    end
    clear_inputs();
    test_resp_single();
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_rr_reads();
    test_write_burst();
    test_stall();
    test_max_outstanding();
    test_resp_burst();
    test_random();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
